iter_divider: RTL

Multi-cycle radix-2 restoring divider. It is the responder side of the divisor/dividend/dout stream handshake that the EXE stage drives for `div.w`, `mod.w`, `div.wu` and `mod.wu`. The EXE stage instantiates it twice, once with SIGNED=1 and once with SIGNED=0, as a port-compatible drop-in for the vendor divider IP. It returns quotient and remainder packed in one word after a fixed latency.

---
 rtl/div_pkg.sv | 22 ++
 rtl/div_step.sv | 24 ++
 rtl/iter_divider.sv | 132 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared divider types: FSM state encoding and result packing.
// EXE slices div_result with the same quotient-high layout.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int DIV_W = 32;

  // Quotient in the upper half, remainder in the lower half.
  function automatic logic [2*DIV_W-1:0] pack_qr(
    input logic [DIV_W-1:0] q,
    input logic [DIV_W-1:0] r
  );
    return {q, r};
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift in the next
// dividend bit, subtract the divisor if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] trial;

  // The partial remainder never exceeds the divisor, so one
  // extra bit above the shifted remainder holds the borrow.
  always_comb begin
    trial   = {rem_in, bit_in} - {2'b00, divisor};
    q_bit   = ~trial[WIDTH+1];
    rem_out = q_bit ? trial[WIDTH:0]
                    : {rem_in[WIDTH-1:0], bit_in};
  end

endmodule

// File: rtl/iter_divider.sv
// Radix-2 restoring divider, {quotient, remainder} after
// WIDTH+2 edges; drop-in for the vendor divider stream port.
module iter_divider
  import div_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SIGNED = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata,
  output logic               m_axis_dout_tvalid
);

  localparam int CW = $clog2(WIDTH);

  div_state_t state, state_nx;

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH:0]     rem;
  logic               neg_q;
  logic               neg_r;

  logic               accept;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     rem_step;
  logic               q_bit;
  logic               last;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;
  logic [2*WIDTH-1:0] qr_next;

  assign s_axis_divisor_tready  = (state == IDLE);
  assign s_axis_dividend_tready = (state == IDLE);

  assign accept = (state == IDLE)
                & s_axis_divisor_tvalid
                & s_axis_dividend_tvalid;

  assign last = (cnt == CW'(WIDTH - 1));

  // Operand magnitudes; INT_MIN stays 0x80.. read as unsigned.
  always_comb begin
    a_neg = (SIGNED != 0) && s_axis_dividend_tdata[WIDTH-1];
    b_neg = (SIGNED != 0) && s_axis_divisor_tdata[WIDTH-1];
    a_abs = a_neg ? -s_axis_dividend_tdata
                  : s_axis_dividend_tdata;
    b_abs = b_neg ? -s_axis_divisor_tdata
                  : s_axis_divisor_tdata;
  end

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem),
    .bit_in  (q[WIDTH-1]),
    .divisor (dvs),
    .rem_out (rem_step),
    .q_bit   (q_bit)
  );

  // Sign correction of the unsigned magnitude result.
  always_comb begin
    q_fix = neg_q ? -q : q;
    r_fix = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end

  if (WIDTH == DIV_W) begin : g_pack
    assign qr_next = pack_qr(q_fix, r_fix);
  end else begin : g_cat
    assign qr_next = {q_fix, r_fix};
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = CALC;
      CALC: if (last) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Operand capture and one restoring step per CALC cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (accept) begin
        neg_r <= a_neg;
        neg_q <= a_neg ^ b_neg;
        q     <= a_abs;
        dvs   <= b_abs;
        rem   <= '0;
        cnt   <= '0;
      end else if (state == CALC) begin
        rem <= rem_step;
        q   <= {q[WIDTH-2:0], q_bit};
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Result register and one-cycle strobe in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_axis_dout_tdata  <= '0;
      m_axis_dout_tvalid <= 1'b0;
    end else begin
      m_axis_dout_tvalid <= (state == FIX);
      if (state == FIX) m_axis_dout_tdata <= qr_next;
    end
  end

endmodule
